tl_client_arbiter: RTL and testbench

TL_CLIENT_ARBITER -- requirements
Module: tl_client_arbiter

---
 rtl/tl_client_arbiter.sv | 170 +++++++++++++++++
 tb/tb_tl_client_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tl_client_arbiter.sv
// tl_client_arbiter: merges two TileLink-UL client A channels onto one port and
// routes D responses back by source bit 2, limiting outstanding messages per client.
`default_nettype none

module tl_client_arbiter #(
   parameter int MAX_INFLIGHT = 4,
   parameter int BEAT_BYTES   = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    in0_a_valid,
   input  logic [2:0]              in0_a_bits_opcode,
   input  logic [2:0]              in0_a_bits_param,
   input  logic [2:0]              in0_a_bits_size,
   input  logic [1:0]              in0_a_bits_source,
   input  logic [30:0]             in0_a_bits_address,
   input  logic [BEAT_BYTES-1:0]   in0_a_bits_mask,
   input  logic [BEAT_BYTES*8-1:0] in0_a_bits_data,
   input  logic                    in0_a_bits_corrupt,
   output logic                    in0_a_ready,
   output logic                    in0_d_valid,
   output logic [2:0]              in0_d_bits_opcode,
   output logic [2:0]              in0_d_bits_size,
   output logic [1:0]              in0_d_bits_source,
   output logic [BEAT_BYTES*8-1:0] in0_d_bits_data,
   input  logic                    in0_d_ready,
   input  logic                    in1_a_valid,
   input  logic [2:0]              in1_a_bits_opcode,
   input  logic [2:0]              in1_a_bits_param,
   input  logic [2:0]              in1_a_bits_size,
   input  logic [1:0]              in1_a_bits_source,
   input  logic [30:0]             in1_a_bits_address,
   input  logic [BEAT_BYTES-1:0]   in1_a_bits_mask,
   input  logic [BEAT_BYTES*8-1:0] in1_a_bits_data,
   input  logic                    in1_a_bits_corrupt,
   output logic                    in1_a_ready,
   output logic                    in1_d_valid,
   output logic [2:0]              in1_d_bits_opcode,
   output logic [2:0]              in1_d_bits_size,
   output logic [1:0]              in1_d_bits_source,
   output logic [BEAT_BYTES*8-1:0] in1_d_bits_data,
   input  logic                    in1_d_ready,
   output logic                    out_a_valid,
   output logic [2:0]              out_a_bits_opcode,
   output logic [2:0]              out_a_bits_param,
   output logic [2:0]              out_a_bits_size,
   output logic [2:0]              out_a_bits_source,
   output logic [30:0]             out_a_bits_address,
   output logic [BEAT_BYTES-1:0]   out_a_bits_mask,
   output logic [BEAT_BYTES*8-1:0] out_a_bits_data,
   output logic                    out_a_bits_corrupt,
   input  logic                    out_a_ready,
   input  logic                    out_d_valid,
   input  logic [2:0]              out_d_bits_opcode,
   input  logic [2:0]              out_d_bits_size,
   input  logic [2:0]              out_d_bits_source,
   input  logic [BEAT_BYTES*8-1:0] out_d_bits_data,
   output logic                    out_d_ready
);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

   state_t          state_q;
   logic            rr_q, owner_q, hold_q, hold_sel_q;
   logic [3:0]      remaining_q;
   logic [1:0][2:0] inflight_q;
   logic [1:0][3:0] dcnt_q;

   logic       elig0, elig1, sel, a_any, a_fire, first_fire;
   logic [3:0] a_beats_m1, d_beats_m1;
   logic       d_sel, d_fire, d_last;

   // Beats minus one, so a size-7 burst (16 beats) still fits four bits.
   function automatic logic [3:0] beats_m1(input logic [2:0] size, input logic has_data);
      if (has_data && size > 3'd3)
         return 4'((5'd1 << (size - 3'd3)) - 5'd1);
      return 4'd0;
   endfunction

   always_comb begin
      elig0 = in0_a_valid && (inflight_q[0] < 3'(MAX_INFLIGHT));
      elig1 = in1_a_valid && (inflight_q[1] < 3'(MAX_INFLIGHT));
      sel   = 1'b0;
      a_any = 1'b0;
      if (state_q == S_LOCKED) begin
         sel   = owner_q;
         a_any = owner_q ? in1_a_valid : in0_a_valid;
      end else if (hold_q && (hold_sel_q ? in1_a_valid : in0_a_valid)) begin
         // A stalled grant keeps its winner even if the other side became eligible.
         sel   = hold_sel_q;
         a_any = 1'b1;
      end else begin
         sel   = (elig0 && elig1) ? rr_q : elig1;
         a_any = elig0 || elig1;
      end
   end

   assign out_a_valid        = a_any && !reset;
   assign out_a_bits_opcode  = sel ? in1_a_bits_opcode  : in0_a_bits_opcode;
   assign out_a_bits_param   = sel ? in1_a_bits_param   : in0_a_bits_param;
   assign out_a_bits_size    = sel ? in1_a_bits_size    : in0_a_bits_size;
   assign out_a_bits_source  = {sel, sel ? in1_a_bits_source : in0_a_bits_source};
   assign out_a_bits_address = sel ? in1_a_bits_address : in0_a_bits_address;
   assign out_a_bits_mask    = sel ? in1_a_bits_mask    : in0_a_bits_mask;
   assign out_a_bits_data    = sel ? in1_a_bits_data    : in0_a_bits_data;
   assign out_a_bits_corrupt = sel ? in1_a_bits_corrupt : in0_a_bits_corrupt;
   assign in0_a_ready        = out_a_valid && !sel && out_a_ready;
   assign in1_a_ready        = out_a_valid &&  sel && out_a_ready;

   assign a_fire     = out_a_valid && out_a_ready;
   assign first_fire = a_fire && (state_q == S_IDLE);
   assign a_beats_m1 = beats_m1(out_a_bits_size, out_a_bits_opcode[2:1] == 2'b00);

   assign d_sel             = out_d_bits_source[2];
   assign in0_d_valid       = out_d_valid && !d_sel && !reset;
   assign in1_d_valid       = out_d_valid &&  d_sel && !reset;
   assign in0_d_bits_opcode = out_d_bits_opcode;
   assign in1_d_bits_opcode = out_d_bits_opcode;
   assign in0_d_bits_size   = out_d_bits_size;
   assign in1_d_bits_size   = out_d_bits_size;
   assign in0_d_bits_source = out_d_bits_source[1:0];
   assign in1_d_bits_source = out_d_bits_source[1:0];
   assign in0_d_bits_data   = out_d_bits_data;
   assign in1_d_bits_data   = out_d_bits_data;
   assign out_d_ready       = !reset && (d_sel ? in1_d_ready : in0_d_ready);

   assign d_fire     = out_d_valid && out_d_ready;
   assign d_beats_m1 = beats_m1(out_d_bits_size, out_d_bits_opcode == 3'd1);
   assign d_last     = d_fire && (dcnt_q[d_sel] == d_beats_m1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         rr_q        <= 1'b0;
         owner_q     <= 1'b0;
         hold_q      <= 1'b0;
         hold_sel_q  <= 1'b0;
         remaining_q <= 4'd0;
         inflight_q  <= '0;
         dcnt_q      <= '0;
      end else begin
         hold_q     <= out_a_valid && !out_a_ready && (state_q == S_IDLE);
         hold_sel_q <= sel;
         if (first_fire) begin
            rr_q <= !sel;
            if (a_beats_m1 != 4'd0) begin
               state_q     <= S_LOCKED;
               owner_q     <= sel;
               remaining_q <= a_beats_m1;
            end
         end else if (a_fire) begin
            remaining_q <= remaining_q - 4'd1;
            if (remaining_q == 4'd1)
               state_q <= S_IDLE;
         end
         if (d_fire)
            dcnt_q[d_sel] <= d_last ? 4'd0 : dcnt_q[d_sel] + 4'd1;
         for (int k = 0; k < 2; k++) begin
            if (first_fire && (sel == 1'(k)) && !(d_last && (d_sel == 1'(k))))
               inflight_q[k] <= inflight_q[k] + 3'd1;
            else if (d_last && (d_sel == 1'(k)) && !(first_fire && (sel == 1'(k)))
                     && (inflight_q[k] != 3'd0))
               inflight_q[k] <= inflight_q[k] - 3'd1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_tl_client_arbiter.sv
// Directed self-checking bench for tl_client_arbiter.
`default_nettype none

module tb_tl_client_arbiter;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic        in0_a_valid, in1_a_valid, in0_a_ready, in1_a_ready;
   logic [2:0]  in0_a_bits_opcode, in1_a_bits_opcode, in0_a_bits_param, in1_a_bits_param;
   logic [2:0]  in0_a_bits_size, in1_a_bits_size;
   logic [1:0]  in0_a_bits_source, in1_a_bits_source;
   logic [30:0] in0_a_bits_address, in1_a_bits_address;
   logic [7:0]  in0_a_bits_mask, in1_a_bits_mask;
   logic [63:0] in0_a_bits_data, in1_a_bits_data;
   logic        in0_a_bits_corrupt, in1_a_bits_corrupt;
   logic        in0_d_valid, in1_d_valid, in0_d_ready, in1_d_ready;
   logic [2:0]  in0_d_bits_opcode, in1_d_bits_opcode, in0_d_bits_size, in1_d_bits_size;
   logic [1:0]  in0_d_bits_source, in1_d_bits_source;
   logic [63:0] in0_d_bits_data, in1_d_bits_data;
   logic        out_a_valid, out_a_ready, out_a_bits_corrupt;
   logic [2:0]  out_a_bits_opcode, out_a_bits_param, out_a_bits_size, out_a_bits_source;
   logic [30:0] out_a_bits_address;
   logic [7:0]  out_a_bits_mask;
   logic [63:0] out_a_bits_data;
   logic        out_d_valid, out_d_ready;
   logic [2:0]  out_d_bits_opcode, out_d_bits_size, out_d_bits_source;
   logic [63:0] out_d_bits_data;

   int n_chk  = 0;
   int n_pass = 0;

   tl_client_arbiter #(.MAX_INFLIGHT(4), .BEAT_BYTES(8)) dut (
      .clock(clock), .reset(reset),
      .in0_a_valid(in0_a_valid), .in0_a_bits_opcode(in0_a_bits_opcode),
      .in0_a_bits_param(in0_a_bits_param), .in0_a_bits_size(in0_a_bits_size),
      .in0_a_bits_source(in0_a_bits_source), .in0_a_bits_address(in0_a_bits_address),
      .in0_a_bits_mask(in0_a_bits_mask), .in0_a_bits_data(in0_a_bits_data),
      .in0_a_bits_corrupt(in0_a_bits_corrupt), .in0_a_ready(in0_a_ready),
      .in0_d_valid(in0_d_valid), .in0_d_bits_opcode(in0_d_bits_opcode),
      .in0_d_bits_size(in0_d_bits_size), .in0_d_bits_source(in0_d_bits_source),
      .in0_d_bits_data(in0_d_bits_data), .in0_d_ready(in0_d_ready),
      .in1_a_valid(in1_a_valid), .in1_a_bits_opcode(in1_a_bits_opcode),
      .in1_a_bits_param(in1_a_bits_param), .in1_a_bits_size(in1_a_bits_size),
      .in1_a_bits_source(in1_a_bits_source), .in1_a_bits_address(in1_a_bits_address),
      .in1_a_bits_mask(in1_a_bits_mask), .in1_a_bits_data(in1_a_bits_data),
      .in1_a_bits_corrupt(in1_a_bits_corrupt), .in1_a_ready(in1_a_ready),
      .in1_d_valid(in1_d_valid), .in1_d_bits_opcode(in1_d_bits_opcode),
      .in1_d_bits_size(in1_d_bits_size), .in1_d_bits_source(in1_d_bits_source),
      .in1_d_bits_data(in1_d_bits_data), .in1_d_ready(in1_d_ready),
      .out_a_valid(out_a_valid), .out_a_bits_opcode(out_a_bits_opcode),
      .out_a_bits_param(out_a_bits_param), .out_a_bits_size(out_a_bits_size),
      .out_a_bits_source(out_a_bits_source), .out_a_bits_address(out_a_bits_address),
      .out_a_bits_mask(out_a_bits_mask), .out_a_bits_data(out_a_bits_data),
      .out_a_bits_corrupt(out_a_bits_corrupt), .out_a_ready(out_a_ready),
      .out_d_valid(out_d_valid), .out_d_bits_opcode(out_d_bits_opcode),
      .out_d_bits_size(out_d_bits_size), .out_d_bits_source(out_d_bits_source),
      .out_d_bits_data(out_d_bits_data), .out_d_ready(out_d_ready)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic clear_inputs();
      in0_a_valid = 0; in0_a_bits_opcode = 3'd4; in0_a_bits_param = 0; in0_a_bits_size = 3'd3;
      in0_a_bits_source = 0; in0_a_bits_address = 31'h100; in0_a_bits_mask = 8'hff;
      in0_a_bits_data = 64'h0; in0_a_bits_corrupt = 0; in0_d_ready = 1;
      in1_a_valid = 0; in1_a_bits_opcode = 3'd4; in1_a_bits_param = 0; in1_a_bits_size = 3'd3;
      in1_a_bits_source = 0; in1_a_bits_address = 31'h200; in1_a_bits_mask = 8'hff;
      in1_a_bits_data = 64'h0; in1_a_bits_corrupt = 0; in1_d_ready = 1;
      out_a_ready = 1; out_d_valid = 0; out_d_bits_opcode = 0; out_d_bits_size = 3'd3;
      out_d_bits_source = 0; out_d_bits_data = 0;
   endtask

   // Inputs change 2 time units after a rising edge; checks follow 1 unit later.
   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1;
      tick();
      reset = 0;
      #1;
   endtask

   initial begin
      clear_inputs();
      #2;
      // Outputs forced low while reset is high, even with active inputs
      in0_a_valid = 1; out_d_valid = 1; out_d_bits_source = 3'b000;
      #1;
      chk("rst_out_a_valid", out_a_valid, 0);
      chk("rst_in0_a_ready", in0_a_ready, 0);
      chk("rst_in0_d_valid", in0_d_valid, 0);
      chk("rst_out_d_ready", out_d_ready, 0);
      chk("rst_inflight0", dut.inflight_q[0], 0);

      // Round-robin alternation between two Get streams
      do_reset();
      in0_a_valid = 1; in0_a_bits_source = 2'd1;
      in1_a_valid = 1; in1_a_bits_source = 2'd2;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("rr_src", out_a_bits_source, (i % 2 == 0) ? 3'b001 : 3'b110);
         chk("rr_in1_ready", in1_a_ready, (i % 2 == 0) ? 1'b0 : 1'b1);
         chk("rr_addr", out_a_bits_address, (i % 2 == 0) ? 31'h100 : 31'h200);
         tick(); #1;
      end

      // Four-beat PutFull from client 0 holds the bus, with one stall cycle
      do_reset();
      in0_a_valid = 1; in0_a_bits_opcode = 3'd0; in0_a_bits_size = 3'd5;
      in1_a_valid = 1;
      for (int c = 0; c < 5; c++) begin
         out_a_ready = (c == 2) ? 1'b0 : 1'b1;
         in0_a_bits_data = 64'(c);
         #1;
         chk("burst_valid", out_a_valid, 1);
         chk("burst_owner", out_a_bits_source[2], 0);
         chk("burst_in1_ready", in1_a_ready, 0);
         chk("burst_in0_ready", in0_a_ready, (c == 2) ? 1'b0 : 1'b1);
         tick();
      end
      #1;
      chk("burst_next_owner", out_a_bits_source[2], 1);
      chk("burst_next_in1_ready", in1_a_ready, 1);

      // Inflight limit on client 0 and unblocking by a single-beat D
      do_reset();
      in0_a_valid = 1;
      for (int i = 0; i < 4; i++) begin
         #1; chk("lim_in0_ready", in0_a_ready, 1);
         tick();
      end
      #1;
      chk("lim_blocked_ready", in0_a_ready, 0);
      chk("lim_blocked_valid", out_a_valid, 0);
      in1_a_valid = 1;
      #1;
      chk("lim_in1_granted", out_a_bits_source[2], 1);
      chk("lim_in1_ready", in1_a_ready, 1);
      tick();
      in1_a_valid = 0;
      out_d_valid = 1; out_d_bits_opcode = 3'd1; out_d_bits_size = 3'd3; out_d_bits_source = 3'b000;
      #1;
      chk("lim_d_valid0", in0_d_valid, 1);
      chk("lim_d_ready", out_d_ready, 1);
      chk("lim_still_blocked", in0_a_ready, 0);
      tick();
      out_d_valid = 0;
      #1;
      chk("lim_unblocked", in0_a_ready, 1);

      // Eight-beat AccessAckData to client 1
      do_reset();
      in1_a_valid = 1;
      tick();
      in1_a_valid = 0;
      out_d_valid = 1; out_d_bits_opcode = 3'd1; out_d_bits_size = 3'd6; out_d_bits_source = 3'b101;
      for (int i = 0; i < 8; i++) begin
         out_d_bits_data = 64'hA5A5_0000_0000_0000 | 64'(i);
         #1;
         chk("d8_valid1", in1_d_valid, 1);
         chk("d8_valid0", in0_d_valid, 0);
         chk("d8_src", in1_d_bits_source, 2'b01);
         chk("d8_data", in1_d_bits_data, 64'hA5A5_0000_0000_0000 | 64'(i));
         chk("d8_inflight_held", dut.inflight_q[1], 1);
         tick();
      end
      out_d_valid = 0;
      #1;
      chk("d8_inflight_dec", dut.inflight_q[1], 0);

      // Simultaneous A first-beat and D last-beat for client 1
      do_reset();
      in1_a_valid = 1;
      tick();
      out_d_valid = 1; out_d_bits_opcode = 3'd0; out_d_bits_size = 3'd3; out_d_bits_source = 3'b100;
      #1;
      chk("both_a_ready", in1_a_ready, 1);
      tick();
      in1_a_valid = 0; out_d_valid = 0;
      #1;
      chk("both_inflight", dut.inflight_q[1], 1);

      // Stray D to an idle client must not wrap the counter
      do_reset();
      out_d_valid = 1; out_d_bits_opcode = 3'd0; out_d_bits_source = 3'b000;
      tick();
      out_d_valid = 0;
      #1;
      chk("sat_inflight0", dut.inflight_q[0], 0);

      // Reset in the middle of a four-beat burst
      do_reset();
      in0_a_valid = 1; in0_a_bits_opcode = 3'd0; in0_a_bits_size = 3'd5;
      in1_a_valid = 1;
      tick(); tick();
      reset = 1;
      #1;
      chk("mid_rst_valid", out_a_valid, 0);
      chk("mid_rst_in0_ready", in0_a_ready, 0);
      chk("mid_rst_in1_ready", in1_a_ready, 0);
      chk("mid_rst_state", dut.state_q, 0);
      reset = 0;
      in0_a_valid = 0;
      #1;
      chk("post_rst_valid", out_a_valid, 1);
      chk("post_rst_owner", out_a_bits_source[2], 1);
      chk("post_rst_in1_ready", in1_a_ready, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
